// File: rtl/adpll_cfg_master.sv
// adpll_cfg_master: autonomous ADPLL bring-up master (soft reset, FCW/mode, enable, lock poll).
// Define ADPLL_CFG_SAT_CHECK_EN to add a post-lock SAT read and the err_sat output.
`ifndef FCWW
`define FCWW 28
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 'h00
`endif
`ifndef FCW
`define FCW 'h04
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 'h08
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 'h0C
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 'h10
`endif
`ifndef ADPLL_SAT
`define ADPLL_SAT 'h14
`endif

module adpll_cfg_master #(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 64,
    parameter int SRST_WAIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [`FCWW-1:0]         fcw_in,
    input  logic [1:0]               mode_in,
    output logic                     busy,
    output logic                     done,
    output logic                     locked,
    output logic                     err_timeout,
`ifdef ADPLL_CFG_SAT_CHECK_EN
    output logic                     err_sat,
`endif
    output logic                     valid,
    output logic [`ADPLL_ADDR_W-1:0] address,
    output logic [31:0]              wdata,
    output logic                     wstrb,
    input  logic [31:0]              rdata,
    input  logic                     ready
);
    localparam int AW = `ADPLL_ADDR_W;
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int CW = $clog2(POLL_GAP + SRST_WAIT + 1);
    localparam logic [PW-1:0] MAXP = PW'(MAX_POLLS);

    typedef enum logic [3:0] {
        IDLE, WR_SRST, WR_FCW, WR_MODE, WR_EN, RD_LOCK, POLL_WAIT, WR_DIS,
`ifdef ADPLL_CFG_SAT_CHECK_EN
        RD_SAT,
`endif
        GAP, FIN
    } state_t;

    state_t state, state_n, ret, ret_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] polls, polls_n, polls_inc;
    logic [`FCWW-1:0] fcw;
    logic [1:0] mode;
    logic locked_n, err_timeout_n, wr, rd;
    logic [AW-1:0] address_n;
    logic [31:0] wdata_n;
    logic unused_rdata;
`ifdef ADPLL_CFG_SAT_CHECK_EN
    logic err_sat_n;
`endif

    assign unused_rdata = ^rdata[31:1];
    assign wr = state inside {WR_SRST, WR_FCW, WR_MODE, WR_EN, WR_DIS};
`ifdef ADPLL_CFG_SAT_CHECK_EN
    assign rd = state inside {RD_LOCK, RD_SAT};
`else
    assign rd = state == RD_LOCK;
`endif
    assign valid = wr || rd;
    assign wstrb = wr;
    assign busy  = state != IDLE && state != FIN;
    assign done  = state == FIN;
    assign polls_inc = (polls == MAXP) ? polls : polls + PW'(1);

    // Each access ends in GAP (ready still high from the registered valid); ret picks what follows.
    always_comb begin
        state_n       = state;
        ret_n         = ret;
        cnt_n         = cnt;
        polls_n       = polls;
        locked_n      = locked;
        err_timeout_n = err_timeout;
`ifdef ADPLL_CFG_SAT_CHECK_EN
        err_sat_n     = err_sat;
`endif
        case (state)
            IDLE: if (start) begin
                state_n       = WR_SRST;
                locked_n      = 1'b0;
                err_timeout_n = 1'b0;
                polls_n       = '0;
`ifdef ADPLL_CFG_SAT_CHECK_EN
                err_sat_n     = 1'b0;
`endif
            end
            WR_SRST: if (ready) {state_n, ret_n, cnt_n} = {GAP, WR_FCW, CW'(SRST_WAIT)};
            WR_FCW:  if (ready) {state_n, ret_n, cnt_n} = {GAP, WR_MODE, CW'(0)};
            WR_MODE: if (ready) {state_n, ret_n, cnt_n} = {GAP, WR_EN, CW'(0)};
            WR_EN:   if (ready) {state_n, ret_n, cnt_n} = {GAP, RD_LOCK, CW'(0)};
            WR_DIS:  if (ready) {state_n, ret_n, cnt_n} = {GAP, FIN, CW'(0)};
            RD_LOCK: if (ready) begin
                polls_n = polls_inc;
                state_n = GAP;
                cnt_n   = '0;
                if (rdata[0]) begin
                    locked_n = 1'b1;
`ifdef ADPLL_CFG_SAT_CHECK_EN
                    ret_n    = RD_SAT;
`else
                    ret_n    = FIN;
`endif
                end else if (polls_inc == MAXP) begin
                    err_timeout_n = 1'b1;
                    ret_n         = WR_DIS;
                end else begin
                    // POLL_WAIT doubles as the bus gap, so the idle span is exactly POLL_GAP
                    state_n = POLL_WAIT;
                    cnt_n   = CW'(POLL_GAP - 1);
                end
            end
`ifdef ADPLL_CFG_SAT_CHECK_EN
            RD_SAT: if (ready) begin
                {state_n, cnt_n} = {GAP, CW'(0)};
                err_sat_n        = rdata[0] ? 1'b1 : err_sat;
                ret_n            = rdata[0] ? WR_DIS : FIN;
            end
`endif
            POLL_WAIT: if (cnt == '0) state_n = RD_LOCK; else cnt_n = cnt - CW'(1);
            GAP:       if (cnt == '0) state_n = ret; else cnt_n = cnt - CW'(1);
            FIN:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        address_n = address;
        wdata_n   = wdata;
        case (state_n)
            WR_SRST: {address_n, wdata_n} = {AW'(`ADPLL_SOFT_RST), 32'd1};
            WR_FCW:  {address_n, wdata_n} = {AW'(`FCW), 32'(fcw)};
            WR_MODE: {address_n, wdata_n} = {AW'(`ADPLL_MODE), {30'b0, mode}};
            WR_EN:   {address_n, wdata_n} = {AW'(`ADPLL_EN), 32'd1};
            WR_DIS:  {address_n, wdata_n} = {AW'(`ADPLL_EN), 32'd0};
            RD_LOCK: address_n = AW'(`ADPLL_LOCK);
`ifdef ADPLL_CFG_SAT_CHECK_EN
            RD_SAT:  address_n = AW'(`ADPLL_SAT);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ret         <= IDLE;
            cnt         <= '0;
            polls       <= '0;
            locked      <= 1'b0;
            err_timeout <= 1'b0;
            address     <= '0;
            wdata       <= '0;
            fcw         <= '0;
            mode        <= '0;
`ifdef ADPLL_CFG_SAT_CHECK_EN
            err_sat     <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            ret         <= ret_n;
            cnt         <= cnt_n;
            polls       <= polls_n;
            locked      <= locked_n;
            err_timeout <= err_timeout_n;
            address     <= address_n;
            wdata       <= wdata_n;
`ifdef ADPLL_CFG_SAT_CHECK_EN
            err_sat     <= err_sat_n;
`endif
            if (state == IDLE && start) begin
                fcw  <= fcw_in;
                mode <= mode_in;
            end
        end
    end
endmodule

// File: doc/adpll_cfg_master.md
Name: adpll_cfg_master

Overview:
- Bus initiator that drives the ADPLL register interface (valid/address/wdata/wstrb; ready/rdata) from the master side.
- On a start pulse it runs a fixed bring-up sequence:
  - soft reset;
  - program FCW and mode;
  - enable;
  - poll ADPLL_LOCK until lock or timeout.
- Sits between the system controller and the ADPLL control register block. It replaces CPU firmware for autonomous channel switching.

Parameters:
- POLL_GAP, 16: idle cycles between consecutive ADPLL_LOCK reads (≥1).
- MAX_POLLS, 64: ADPLL_LOCK reads before timeout (≥1).
- SRST_WAIT, 2: extra idle cycles after the soft-reset write, before the next transaction.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: one-cycle request; sampled only in IDLE.
- fcw_in, input, `FCWW: channel frequency control word; latched on accepted start.
- mode_in, input, 2: adpll_mode value; latched on accepted start.
- busy, output, 1: high from the cycle after accepted start until done.
- done, output, 1: one-cycle pulse at sequence end.
- locked, output, 1: lock result; held until next accepted start.
- err_timeout, output, 1: MAX_POLLS reads without lock; held until next accepted start.
- valid, output, 1: bus request.
- address, output, `ADPLL_ADDR_W: register address (`ADPLL_* / `FCW macros).
- wdata, output, 32: write data.
- wstrb, output, 1: 1 = write, 0 = read.
- rdata, input, 32: read data, valid while ready=1.
- ready, input, 1: slave acknowledge; registered copy of valid.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Asynchronous reset mid-sequence drops valid immediately and abandons the sequence; no done pulse.
- Transaction timing, 3 cycles per access:
  - ISSUE: valid=1, address/wdata/wstrb stable. Completes on the clk edge where ready=1, normally the 2nd ISSUE cycle.
  - GAP: 1 cycle, valid=0, ready ignored. Required because ready lags valid by one cycle.
  - Writes land twice in the slave; this is harmless because all written registers are idempotent.
  - Reads capture rdata[0] at completion.
- States and transitions:
  - IDLE: start=1 → latch fcw_in/mode_in, clear locked/err_timeout/poll count → WR_SRST. start while busy is ignored.
  - WR_SRST: write `ADPLL_SOFT_RST = 1. GAP is then extended by SRST_WAIT cycles to let the soft reset self-clear.
  - WR_FCW: write `FCW = zero-extended fcw_in.
  - WR_MODE: write `ADPLL_MODE = {30'b0, mode_in}.
  - WR_EN: write `ADPLL_EN = 1.
  - RD_LOCK: read `ADPLL_LOCK; increment poll count.
    - rdata[0]=1 → locked=1 → FIN.
    - rdata[0]=0 and poll count = MAX_POLLS → err_timeout=1 → WR_DIS.
    - Otherwise → POLL_WAIT.
  - POLL_WAIT: POLL_GAP idle cycles, valid=0 → RD_LOCK.
  - WR_DIS: write `ADPLL_EN = 0 → FIN.
  - FIN: done=1 for one cycle, busy=0 → IDLE.
- Poll count width is clog2(MAX_POLLS+1); it saturates and never wraps.
- The first lock read follows the WR_EN GAP directly, with no POLL_GAP.
- When valid=0: address and wdata hold their last value, wstrb=0.
- ready=1 while valid=0 outside GAP is a protocol error and is ignored.
- If ready is late, ISSUE holds with no timeout; the slave always responds.

Optional Feature:
- Macro: ADPLL_CFG_SAT_CHECK_EN.
- When defined:
  - Adds output err_sat (1 bit, reset 0, cleared on accepted start).
  - After a successful lock read, one extra read of `ADPLL_SAT (state RD_SAT).
  - If rdata[0]=1: err_sat=1, locked stays 1, then WR_DIS (disable) → FIN.
  - Otherwise → FIN.
- When undefined: no err_sat port and no RD_SAT state; the lock path goes straight to FIN.

Test Plan:
1. Nominal, SRST_WAIT=2; start with fcw_in=0x2620000, mode_in=1; slave lock=1 on first read.
   - Bus writes: SOFT_RST=1, FCW=0x02620000, MODE=1, EN=1, each with valid high exactly 2 cycles.
   - Then one LOCK read.
   - done pulses at cycle 18 after start, with locked=1, err_timeout=0.
2. Lock on 3rd poll, POLL_GAP=16: three LOCK reads separated by exactly 16 idle cycles → locked=1, poll count=3.
3. Timeout with MAX_POLLS=4 and lock stuck 0: 4 reads, then write EN=0, then done → err_timeout=1, locked=0.
4. Busy and re-start:
   - start pulsed during WR_FCW → ignored; sequence unchanged.
   - Second start after done → locked/err_timeout cleared the cycle after the start is accepted.
5. Reset mid-sequence: assert rst during a WR_MODE ISSUE cycle → valid=0 asynchronously, busy=0, no done; the next start runs the full sequence from WR_SRST.
6. ADPLL_CFG_SAT_CHECK_EN defined; lock=1, sat=1 → SAT read, then EN=0 write → err_sat=1, locked=1, done pulse.
